// File: rtl/led_rate_selector.sv
// led_rate_selector: debounced button cycles an LED through OFF/SOLID/10/5/2/1 Hz blink modes.
module led_rate_selector #(
  parameter int g_DEBOUNCE_LIMIT = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch,
  input  logic       i_Blink_10HZ,
  input  logic       i_Blink_5HZ,
  input  logic       i_Blink_2HZ,
  input  logic       i_Blink_1HZ,
  output logic       o_LED,
  output logic [2:0] o_Mode
);
  localparam int CW = $clog2(g_DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LIM = CW'(g_DEBOUNCE_LIMIT - 1);

  typedef enum logic [2:0] {OFF, SOLID, HZ10, HZ5, HZ2, HZ1} mode_t;

  logic          sync1_q, sync2_q, deb_q, deb_d, prev_q, adv_q, led_q, led_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mode_t         mode_q, mode_d;
  logic          diff, at_lim;

  assign diff   = sync2_q ^ deb_q;
  assign at_lim = cnt_q == LIM;
  assign cnt_d  = (diff && !at_lim) ? cnt_q + 1'b1 : '0;
  assign deb_d  = (diff && at_lim) ? sync2_q : deb_q;

  // Unreachable codes 6/7 fall back to OFF regardless of the advance pulse.
  assign mode_d = (mode_q > HZ1) ? OFF :
                  !adv_q ? mode_q :
                  (mode_q == HZ1) ? OFF : mode_t'(mode_q + 3'd1);

  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      SOLID:   led_d = 1'b1;
      HZ10:    led_d = i_Blink_10HZ;
      HZ5:     led_d = i_Blink_5HZ;
      HZ2:     led_d = i_Blink_2HZ;
      HZ1:     led_d = i_Blink_1HZ;
      default: led_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      adv_q   <= 1'b0;
      mode_q  <= OFF;
      led_q   <= 1'b0;
    end else begin
      sync1_q <= i_Switch;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      prev_q  <= deb_q;
      adv_q   <= prev_q & ~deb_q;
      mode_q  <= mode_d;
      led_q   <= led_d;
    end
  end

  assign o_LED  = led_q;
  assign o_Mode = mode_q;
endmodule
